// File: rtl/mips_encoder_if.sv
// rtl/mips_encoder_if.sv - field-bundle input, encoded-word output and status bus of the MIPS encoder
interface mips_encoder_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       fmt;
  logic [5:0]       opcode;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shamt;
  logic [5:0]       funct;
  logic [15:0]      imm;
  logic [25:0]      addr;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] enc_count;
  logic             err;

  // producer of field bundles and consumer of encoded words
  modport master (
    output in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm, addr, out_ready,
    input  in_ready, out_valid, out_instr, level, enc_count, err
  );

  // the encoder itself
  modport slave (
    input  in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm, addr, out_ready,
    output in_ready, out_valid, out_instr, level, enc_count, err
  );
endinterface

// File: rtl/mips_encoder.sv
// rtl/mips_encoder.sv - packs MIPS fields into 32-bit words behind a small FIFO; MIPS_ENC_CHECK_EN enables consistency checking
module mips_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  mips_encoder_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      word;
  logic             bad;
  logic             ready;
  logic             valid;
  logic             accept;
  logic             push;
  logic             pop;

  // field packing for the selected format; the reserved format encodes as NOP
  always_comb begin
    word = 32'h0000_0000;
    case (bus.fmt)
      2'b00:   word = {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
      2'b01:   word = {bus.opcode, bus.rs, bus.rt, bus.imm};
      2'b10:   word = {bus.opcode, bus.addr};
      default: word = 32'h0000_0000;
    endcase
  end

`ifdef MIPS_ENC_CHECK_EN
  logic err_q;

  // flag bundles whose opcode does not belong to the selected format
  always_comb begin
    bad = 1'b0;
    case (bus.fmt)
      2'b00:   bad = (bus.opcode != 6'd0);
      2'b01:   bad = (bus.opcode == 6'd0) || (bus.opcode == 6'd2) || (bus.opcode == 6'd3);
      2'b10:   bad = (bus.opcode != 6'd2) && (bus.opcode != 6'd3);
      default: bad = 1'b1;
    endcase
  end

  // one-cycle error pulse after a rejected bundle is handshaken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= accept && bad;
  end

  assign bus.err = err_q;
`else
  assign bad     = 1'b0;
  assign bus.err = 1'b0;
`endif

  // handshake qualifiers come only from registered occupancy
  assign ready  = (level_q != FULL);
  assign valid  = (level_q != '0);
  assign accept = bus.in_valid && ready;
  assign push   = accept && !bad;
  assign pop    = valid && bus.out_ready;

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.out_instr = valid ? mem[rd_ptr] : 32'h0000_0000;
  assign bus.level     = level_q;
  assign bus.enc_count = count_q;

  // storage array; contents are don't-care until the occupancy says otherwise
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  // pointers, occupancy and the accepted-bundle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        count_q <= count_q + CNT_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_encoder.sv
// tb/tb_mips_encoder.sv - directed self-checking bench for mips_encoder
module tb_mips_encoder;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  mips_encoder_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  mips_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                       input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ad);
    bus.fmt    = f;
    bus.opcode = op;
    bus.rs     = s;
    bus.rt     = t;
    bus.rd     = d;
    bus.shamt  = sh;
    bus.funct  = fn;
    bus.imm    = im;
    bus.addr   = ad;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    tick();
    tick();
    n_total++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_total++; if (bus.out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_out_instr got=%h exp=00000000", bus.out_instr); end
    n_total++; if (bus.level !== 3'd0) begin n_bad++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    n_total++; if (bus.enc_count !== 4'd0) begin n_bad++; $display("FAIL reset_enc_count got=%0d exp=0", bus.enc_count); end
    n_total++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    rst_n = 1'b1;
    tick();
    n_total++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_r_format();
    bus.out_ready = 1'b1;
    drive(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hFFFF, 26'h3FF_FFFF);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL r_out_valid got=%b exp=1", bus.out_valid); end
    n_total++; if (bus.out_instr !== 32'h0022_1820) begin n_bad++; $display("FAIL r_out_instr got=%h exp=00221820", bus.out_instr); end
    n_total++; if (bus.enc_count !== 4'd1) begin n_bad++; $display("FAIL r_enc_count got=%0d exp=1", bus.enc_count); end
    n_total++; if (bus.level !== 3'd1) begin n_bad++; $display("FAIL r_level got=%0d exp=1", bus.level); end
    tick();
    n_total++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL r_drained got=%b exp=0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_i_j_format();
    drive(2'b01, 6'h08, 5'd1, 5'd2, 5'h1F, 5'h1F, 6'h3F, 16'd5, 26'h3FF_FFFF);
    bus.in_valid = 1'b1;
    tick();
    n_total++; if (bus.out_instr !== 32'h2022_0005) begin n_bad++; $display("FAIL i_out_instr got=%h exp=20220005", bus.out_instr); end
    drive(2'b10, 6'd2, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'd3);
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.out_instr !== 32'h2022_0005) begin n_bad++; $display("FAIL i_head_hold got=%h exp=20220005", bus.out_instr); end
    n_total++; if (bus.level !== 3'd2) begin n_bad++; $display("FAIL ij_level got=%0d exp=2", bus.level); end
    bus.out_ready = 1'b1;
    tick();
    n_total++; if (bus.out_instr !== 32'h0800_0003) begin n_bad++; $display("FAIL j_out_instr got=%h exp=08000003", bus.out_instr); end
    tick();
    bus.out_ready = 1'b0;
    n_total++; if (bus.level !== 3'd0) begin n_bad++; $display("FAIL ij_drained got=%0d exp=0", bus.level); end
    n_total++; if (bus.enc_count !== 4'd3) begin n_bad++; $display("FAIL ij_enc_count got=%0d exp=3", bus.enc_count); end
  endtask

  task automatic test_consistency();
    logic [2:0] exp_lvl;
    logic       exp_err;
    logic [3:0] exp_cnt;
`ifdef MIPS_ENC_CHECK_EN
    exp_lvl = 3'd0;
    exp_err = 1'b1;
`else
    exp_lvl = 3'd1;
    exp_err = 1'b0;
`endif
    do_reset();
    drive(2'b11, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h3FF_FFFF);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.level !== exp_lvl) begin n_bad++; $display("FAIL nop_level got=%0d exp=%0d", bus.level, exp_lvl); end
    n_total++; if (bus.err !== exp_err) begin n_bad++; $display("FAIL nop_err got=%b exp=%b", bus.err, exp_err); end
    n_total++; if (bus.out_instr !== 32'h0) begin n_bad++; $display("FAIL nop_out_instr got=%h exp=00000000", bus.out_instr); end
    tick();
    n_total++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL nop_err_pulse got=%b exp=0", bus.err); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    drive(2'b00, 6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.level !== exp_lvl) begin n_bad++; $display("FAIL rbad_level got=%0d exp=%0d", bus.level, exp_lvl); end
    n_total++; if (bus.err !== exp_err) begin n_bad++; $display("FAIL rbad_err got=%b exp=%b", bus.err, exp_err); end
`ifndef MIPS_ENC_CHECK_EN
    n_total++; if (bus.out_instr !== 32'h2022_1820) begin n_bad++; $display("FAIL rbad_out_instr got=%h exp=20221820", bus.out_instr); end
`endif
    tick();
    n_total++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL rbad_err_pulse got=%b exp=0", bus.err); end
    exp_cnt = (exp_err == 1'b1) ? 4'd0 : 4'd2;
    n_total++; if (bus.enc_count !== exp_cnt) begin n_bad++; $display("FAIL check_enc_count got=%0d exp=%0d", bus.enc_count, exp_cnt); end
  endtask

  task automatic test_fill();
    logic [31:0] exp_w;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(2'b01, 6'h08, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'(k), 26'd0);
      bus.in_valid = 1'b1;
      tick();
    end
    n_total++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_in_ready got=%b exp=0", bus.in_ready); end
    n_total++; if (bus.level !== 3'd4) begin n_bad++; $display("FAIL fill_level got=%0d exp=4", bus.level); end
    drive(2'b01, 6'h08, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0);
    tick();
    n_total++; if (bus.level !== 3'd4) begin n_bad++; $display("FAIL fill_held_level got=%0d exp=4", bus.level); end
    n_total++; if (bus.enc_count !== 4'd4) begin n_bad++; $display("FAIL fill_held_count got=%0d exp=4", bus.enc_count); end
    n_total++; if (bus.out_instr !== 32'h2000_0001) begin n_bad++; $display("FAIL fill_head got=%h exp=20000001", bus.out_instr); end
    bus.out_ready = 1'b1;
    tick();
    n_total++; if (bus.level !== 3'd3) begin n_bad++; $display("FAIL fullpop_level got=%0d exp=3", bus.level); end
    n_total++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL fullpop_in_ready got=%b exp=1", bus.in_ready); end
    n_total++; if (bus.out_instr !== 32'h2000_0002) begin n_bad++; $display("FAIL fullpop_head got=%h exp=20000002", bus.out_instr); end
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.level !== 3'd3) begin n_bad++; $display("FAIL fifth_level got=%0d exp=3", bus.level); end
    n_total++; if (bus.enc_count !== 4'd5) begin n_bad++; $display("FAIL fifth_count got=%0d exp=5", bus.enc_count); end
    for (int k = 3; k <= 5; k++) begin
      exp_w = 32'h2000_0000 | 32'(k);
      n_total++; if (bus.out_instr !== exp_w) begin n_bad++; $display("FAIL drain_order got=%h exp=%h", bus.out_instr, exp_w); end
      tick();
    end
    n_total++; if (bus.level !== 3'd0) begin n_bad++; $display("FAIL drain_level got=%0d exp=0", bus.level); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(2'b01, 6'h08, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h000A, 26'd0);
    bus.in_valid = 1'b1;
    tick();
    drive(2'b01, 6'h08, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h000B, 26'd0);
    tick();
    bus.out_ready = 1'b1;
    drive(2'b01, 6'h08, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h000C, 26'd0);
    tick();
    n_total++; if (bus.level !== 3'd2) begin n_bad++; $display("FAIL b2b_level1 got=%0d exp=2", bus.level); end
    n_total++; if (bus.out_instr !== 32'h2000_000B) begin n_bad++; $display("FAIL b2b_head1 got=%h exp=2000000b", bus.out_instr); end
    drive(2'b01, 6'h08, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h000D, 26'd0);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_total++; if (bus.level !== 3'd2) begin n_bad++; $display("FAIL b2b_level2 got=%0d exp=2", bus.level); end
    n_total++; if (bus.out_instr !== 32'h2000_000C) begin n_bad++; $display("FAIL b2b_head2 got=%h exp=2000000c", bus.out_instr); end
    tick();
    n_total++; if (bus.out_instr !== 32'h2000_000C) begin n_bad++; $display("FAIL b2b_stall got=%h exp=2000000c", bus.out_instr); end
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
    n_total++; if (bus.level !== 3'd0) begin n_bad++; $display("FAIL midrst_level got=%0d exp=0", bus.level); end
    n_total++; if (bus.enc_count !== 4'd0) begin n_bad++; $display("FAIL midrst_count got=%0d exp=0", bus.enc_count); end
    #1;
    rst_n = 1'b1;
    tick();
    n_total++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_count_wrap();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 17; k++) begin
      drive(2'b10, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'(k));
      tick();
    end
    bus.in_valid = 1'b0;
    n_total++; if (bus.enc_count !== 4'd1) begin n_bad++; $display("FAIL wrap_count got=%0d exp=1", bus.enc_count); end
    n_total++; if (bus.out_instr !== 32'h0800_0010) begin n_bad++; $display("FAIL wrap_head got=%h exp=08000010", bus.out_instr); end
    tick();
    n_total++; if (bus.level !== 3'd0) begin n_bad++; $display("FAIL wrap_level got=%0d exp=0", bus.level); end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    test_reset();
    test_r_format();
    test_i_j_format();
    test_consistency();
    test_fill();
    test_back_to_back();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_encoder.md
Name: mips_encoder

Overview:
- Inverse of the instruction decoder: packs opcode/rs/rt/rd/shamt/funct/imm/addr fields plus a format select into one 32-bit MIPS instruction word.
- Encoded words are buffered in a small FIFO with valid/ready handshakes on both sides.
- Feeds instruction memory load and decoder-loopback benches.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
CNT_W, 16, width of the accepted-instruction counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept; high when FIFO not full
fmt  input  2  format: 00 R, 01 I, 10 J, 11 reserved
opcode  input  6  bits 31:26
rs  input  5  bits 25:21 (R, I)
rt  input  5  bits 20:16 (R, I)
rd  input  5  bits 15:11 (R)
shamt  input  5  bits 10:6 (R)
funct  input  6  bits 5:0 (R)
imm  input  16  bits 15:0 (I)
addr  input  26  bits 25:0 (J)
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_instr  output  32  encoded word at FIFO head
level  output  clog2(DEPTH)+1  current FIFO occupancy
enc_count  output  CNT_W  total bundles accepted, modulo 2^CNT_W
err  output  1  consistency-error pulse (optional feature only)

Behaviour:
- Reset (async assert, sync-released logic): FIFO empty; out_valid=0, out_instr=0, level=0, enc_count=0, err=0, in_ready=1 while rst_n=1 after reset. Reset mid-stream discards all buffered words.
- Encoding (combinational, captured on push):
  - R: {opcode,rs,rt,rd,shamt,funct}
  - I: {opcode,rs,rt,imm}
  - J: {opcode,addr}
  - fmt 11: 32'h0000_0000 (NOP)
  - Fields not used by the selected format are ignored.
- Push when in_valid && in_ready at a rising edge; pop when out_valid && out_ready.
- in_ready = (level != DEPTH), derived from registered state; no combinational path from out_ready.
- Latency: word accepted at edge N is visible on out_instr with out_valid=1 after edge N when the FIFO was empty (one cycle).
- out_instr always shows the head entry; it holds stable while out_valid && !out_ready.
- Simultaneous push and pop:
  - FIFO not full: both occur and level is unchanged.
  - FIFO full: in_ready=0, so only the pop occurs; in_ready rises the next cycle.
  - FIFO empty: the pop is ignored (out_valid=0) and the push occurs.
- Read/write pointers are clog2(DEPTH) wide and wrap naturally.
- enc_count increments on every push, wrapping from 2^CNT_W-1 to 0.

Optional Feature:
MIPS_ENC_CHECK_EN
- Defined: an accepted bundle is inconsistent if any of these holds:
  - fmt=11
  - fmt=R with opcode≠0
  - fmt=J with opcode∉{2,3}
  - fmt=I with opcode∈{0,2,3}
- An inconsistent bundle is still handshaken (in_ready is unaffected), but it is not enqueued and enc_count does not increment.
- err pulses high for exactly one cycle after the accepting edge.
- Undefined: err is tied 0, and every accepted bundle is enqueued, including the fmt=11 NOP.

Test Plan:
- R add $3,$1,$2: fmt=00 op=0 rs=1 rt=2 rd=3 shamt=0 funct=0x20, out_ready=1 -> out_instr=0x00221820 one cycle later, enc_count=1.
- I addi $2,$1,5: fmt=01 op=0x08 rs=1 rt=2 imm=5 -> 0x20220005; J: fmt=10 op=2 addr=3 -> 0x08000003.
- Fill: out_ready=0, push 5 bundles back-to-back with DEPTH=4 -> in_ready=0 after the 4th push, level=4, 5th bundle held; then out_ready=1 drains 4 words in push order, and the 5th is accepted on the cycle in_ready rises.
- Concurrent push/pop at level=2 -> level remains 2 and ordering is preserved; assert rst_n=0 mid-stream -> out_valid=0 and level=0 immediately.
- MIPS_ENC_CHECK_EN defined: fmt=00 with op=0x08 -> err=1 for one cycle, level unchanged; undefined: same input -> enqueued as 0x20000000|fields, err=0.
- enc_count wrap: CNT_W=4, push 17 bundles -> enc_count=1.
